// File: rtl/adder_test_seq.sv
// Adder self-test sequencer: LFSR operands, LAT+2 cycles per vector, pass/fail summary on the output mux.
// Optional MISR signature port is built only when ADDER_TEST_SEQ_MISR_EN is defined; start is ignored while busy.
module adder_test_seq #(
    parameter int          N       = 16,
    parameter int          NUM_VEC = 32,
    parameter int          LAT     = 1,
    parameter int unsigned SEED    = 16'h0001,
    parameter int unsigned TAPS    = 16'hB400
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] op_a,
    output logic [N-1:0] op_b,
    output logic         ci,
    input  logic [N-1:0] sum,
    input  logic         co,
    output logic         sel,
    output logic [5:0]   com_res
`ifdef ADDER_TEST_SEQ_MISR_EN
    ,
    output logic [N-1:0] signature
`endif
);

    typedef enum logic [2:0] {IDLE, APPLY, WAIT, CAPTURE, REPORT} state_t;

    localparam logic [N-1:0] SEED_RAW = N'(SEED);
    localparam logic [N-1:0] SEED_N   = (SEED_RAW == '0) ? {{(N-1){1'b0}}, 1'b1} : SEED_RAW;
    localparam logic [N-1:0] TAPS_N   = N'(TAPS);
    localparam logic [7:0]   NUM_VEC8 = 8'(NUM_VEC);
    localparam logic [3:0]   LAT_M1   = 4'((LAT > 0) ? LAT - 1 : 0);

    state_t       state_q, state_d;
    logic [N-1:0] lfsr_q, lfsr_d;
    logic [N-1:0] op_a_q, op_a_d;
    logic [N-1:0] op_b_q, op_b_d;
    logic         ci_q, ci_d;
    logic [7:0]   vec_cnt_q, vec_cnt_d;
    logic [3:0]   wait_cnt_q, wait_cnt_d;
    logic [4:0]   err_cnt_q, err_cnt_d;
    logic         fail_q, fail_d;
    logic         sel_q, sel_d;
    logic         done_q, done_d;
    logic [N:0]   exp_sum;
`ifdef ADDER_TEST_SEQ_MISR_EN
    logic [N-1:0] misr_q, misr_d;
`endif

    function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s);
        return s[0] ? ((s >> 1) ^ TAPS_N) : (s >> 1);
    endfunction

    assign exp_sum = {1'b0, op_a_q} + {1'b0, op_b_q} + {{N{1'b0}}, ci_q};

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        ci_d       = ci_q;
        vec_cnt_d  = vec_cnt_q;
        wait_cnt_d = wait_cnt_q;
        err_cnt_d  = err_cnt_q;
        fail_d     = fail_q;
        sel_d      = sel_q;
        done_d     = 1'b0;
`ifdef ADDER_TEST_SEQ_MISR_EN
        misr_d     = misr_q;
`endif
        case (state_q)
            IDLE, REPORT: begin
                if (start) begin
                    state_d   = APPLY;
                    lfsr_d    = SEED_N;
                    vec_cnt_d = '0;
                    err_cnt_d = '0;
                    fail_d    = 1'b0;
                    sel_d     = 1'b0;
`ifdef ADDER_TEST_SEQ_MISR_EN
                    misr_d    = SEED_N;
`endif
                end
            end
            APPLY: begin
                wait_cnt_d = '0;
                state_d    = (LAT > 0) ? WAIT : CAPTURE;
            end
            WAIT: begin
                if (wait_cnt_q == LAT_M1) state_d = CAPTURE;
                else wait_cnt_d = wait_cnt_q + 4'd1;
            end
            CAPTURE: begin
                if ({co, sum} != exp_sum) begin
                    fail_d = 1'b1;
                    if (err_cnt_q != 5'd31) err_cnt_d = err_cnt_q + 5'd1;
                end
`ifdef ADDER_TEST_SEQ_MISR_EN
                misr_d    = lfsr_step(misr_q) ^ (sum ^ {{(N-1){1'b0}}, co});
`endif
                lfsr_d    = lfsr_step(lfsr_q);
                vec_cnt_d = vec_cnt_q + 8'd1;
                if (vec_cnt_d == NUM_VEC8) begin
                    state_d = REPORT;
                    done_d  = 1'b1;
                    sel_d   = 1'b1;
                end else begin
                    state_d = APPLY;
                end
            end
            default: state_d = IDLE;
        endcase
        // Operands are loaded on the edge entering APPLY so they are stable from APPLY through CAPTURE.
        if (state_d == APPLY && state_q != APPLY) begin
            op_a_d = lfsr_d;
            op_b_d = {lfsr_d[N-2:0], lfsr_d[N-1]};
            ci_d   = lfsr_d[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED_N;
            op_a_q     <= '0;
            op_b_q     <= '0;
            ci_q       <= 1'b0;
            vec_cnt_q  <= '0;
            wait_cnt_q <= '0;
            err_cnt_q  <= '0;
            fail_q     <= 1'b0;
            sel_q      <= 1'b0;
            done_q     <= 1'b0;
`ifdef ADDER_TEST_SEQ_MISR_EN
            misr_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            ci_q       <= ci_d;
            vec_cnt_q  <= vec_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            err_cnt_q  <= err_cnt_d;
            fail_q     <= fail_d;
            sel_q      <= sel_d;
            done_q     <= done_d;
`ifdef ADDER_TEST_SEQ_MISR_EN
            misr_q     <= misr_d;
`endif
        end
    end

    assign busy    = (state_q == APPLY) || (state_q == WAIT) || (state_q == CAPTURE);
    assign done    = done_q;
    assign op_a    = op_a_q;
    assign op_b    = op_b_q;
    assign ci      = ci_q;
    assign sel     = sel_q;
    assign com_res = {fail_q, err_cnt_q};
`ifdef ADDER_TEST_SEQ_MISR_EN
    assign signature = misr_q;
`endif

endmodule

// File: tb/tb_adder_test_seq.sv
// Bench for adder_test_seq: behavioural adder with injectable faults, run-level reference model and done-time scoreboard.
module tb_adder_test_seq;

    localparam int N   = 16;
    localparam int NV  = 32;
    localparam int LAT = 1;

    typedef struct {
        logic [5:0]  com_res;
        logic [15:0] sig;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        busy, done, ci, co, sel;
    logic [15:0] op_a, op_b, sum;
    logic [5:0]  com_res;
    logic [16:0] true_res;
    logic [15:0] signature;
    int          fault_mode = 0;
    int          errors = 0, checks = 0;
    int          done_cnt = 0, busy_cycles = 0;
    exp_t        exp_q[$];

    always #5 clk = ~clk;

    adder_test_seq #(.N(N), .NUM_VEC(NV), .LAT(LAT), .SEED(16'h0001), .TAPS(16'hB400)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .op_a(op_a), .op_b(op_b), .ci(ci), .sum(sum), .co(co),
        .sel(sel), .com_res(com_res)
`ifdef ADDER_TEST_SEQ_MISR_EN
        , .signature(signature)
`endif
    );

`ifndef ADDER_TEST_SEQ_MISR_EN
    assign signature = 16'h0;
`endif

    // Behavioural adder: 0 golden, 1 sum[3] stuck-at-0, 2 every result wrong.
    always_comb begin
        true_res = {1'b0, op_a} + {1'b0, op_b} + {16'h0, ci};
        sum = true_res[15:0];
        co  = true_res[16];
        if (fault_mode == 1) sum[3] = 1'b0;
        else if (fault_mode == 2) sum[0] = ~true_res[0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // Reference: whole-run outcome computed from operand rules and the fault applied to each true sum.
    function automatic exp_t model_run(input int f);
        exp_t        e;
        logic [15:0] l, a, b, misr;
        logic [16:0] t, r;
        int          errs;
        l = 16'h0001; misr = 16'h0001; errs = 0;
        for (int i = 0; i < NV; i++) begin
            a = l;
            b = {l[14:0], l[15]};
            t = {1'b0, a} + {1'b0, b} + {16'h0, l[0]};
            r = t;
            if (f == 1) r[3] = 1'b0;
            if (f == 2) r[0] = ~r[0];
            if (r != t) errs++;
            misr = step(misr) ^ (r[15:0] ^ {15'h0, r[16]});
            l = step(l);
        end
        e.com_res = {errs > 0, (errs > 31) ? 5'd31 : 5'(errs)};
        e.sig = misr;
        return e;
    endfunction

    // Monitor: scores every done pulse against the oldest expected run.
    always @(negedge clk) begin
        if (rst) begin
            busy_cycles = 0;
        end else begin
            if (busy) busy_cycles++;
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("com_res_at_done", 32'(com_res), 32'(e.com_res));
                    check("sel_at_done", 32'(sel), 32'd1);
                    check("busy_at_done", 32'(busy), 32'd0);
                    check("run_cycles", busy_cycles, NV * (LAT + 2));
`ifdef ADDER_TEST_SEQ_MISR_EN
                    check("signature_at_done", 32'(signature), 32'(e.sig));
`endif
                end
                busy_cycles = 0;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic do_run(input int f, input bit spurious, output logic [15:0] sig);
        exp_t e;
        int   d0, k;
        e = model_run(f);
        exp_q.push_back(e);
        fault_mode = f;
        d0 = done_cnt;
        pulse_start();
        check("first_op_a", 32'(op_a), 32'h0001);
        check("first_op_b", 32'(op_b), 32'h0002);
        check("first_ci", 32'(ci), 32'd1);
        check("sel_after_start", 32'(sel), 32'd0);
        check("busy_after_start", 32'(busy), 32'd1);
        if (spurious) begin
            k = $urandom_range(3, 80);
            repeat (k) @(posedge clk);
            #1 start = 1'b1;
            repeat (3) @(posedge clk);
            #1 start = 1'b0;
        end
        for (int i = 0; i < 400 && done_cnt == d0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check("done_count", done_cnt, d0 + 1);
        check("sel_hold", 32'(sel), 32'd1);
        check("com_res_hold", 32'(com_res), 32'(e.com_res));
        sig = signature;
    endtask

    initial begin
        logic [15:0] g1, g2, s1, tmp;
        int          d0;
        rst = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; start = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_com_res", 32'(com_res), 32'd0);
        check("rst_op_a", 32'(op_a), 32'd0);
        check("rst_op_b", 32'(op_b), 32'd0);
        check("rst_ci", 32'(ci), 32'd0);
        check("rst_signature", 32'(signature), 32'd0);

        do_run(0, 1'b0, g1);
        do_run(0, 1'b1, g2);
        do_run(1, 1'b1, s1);
        do_run(2, 1'b0, tmp);
`ifdef ADDER_TEST_SEQ_MISR_EN
        check("sig_golden_repeat", 32'(g2), 32'(g1));
        check("sig_golden_nonzero", 32'(g1 != 16'h0), 32'd1);
        check("sig_stuck_differs", 32'(s1 != g1), 32'd1);
`endif
        for (int r = 0; r < 3; r++) do_run(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), tmp);

        // Abort mid-run with start held in the reset cycle.
        fault_mode = 0;
        exp_q.push_back(model_run(0));
        d0 = done_cnt;
        pulse_start();
        repeat ($urandom_range(20, 60)) @(posedge clk);
        #1 rst = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; start = 1'b0;
        exp_q.delete();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sel", 32'(sel), 32'd0);
        check("abort_com_res", 32'(com_res), 32'd0);
        check("abort_op_a", 32'(op_a), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_signature", 32'(signature), 32'd0);
        repeat (150) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, d0);

        do_run(0, 1'b0, tmp);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
